// File: rtl/hcsr04_emulador.sv
// HC-SR04 responder: measures the trigger pulse, then returns an echo whose width encodes a BCD distance.
// Optional measurement jitter (LFSR, 0-7 mm) is enabled by defining HCSR04_EMULADOR_RUIDO_EN.
module hcsr04_emulador #(
    parameter int CICLOS_POR_MM = 294,
    parameter int TRIG_MIN      = 500,
    parameter int ATRASO        = 10000,
    parameter int ECO_MAX       = 1900000,
    parameter int PAUSA         = 500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        trigger,
    input  logic [11:0] distancia,
    input  logic        sem_objeto,
    output logic        echo,
    output logic        ocupado,
    output logic        erro_trigger,
    output logic [2:0]  db_estado
);
    typedef enum logic [2:0] {
        S_OCIOSO    = 3'd0,
        S_MEDE_TRIG = 3'd1,
        S_ATRASO    = 3'd2,
        S_ECO       = 3'd3,
        S_PAUSA     = 3'd4
    } estado_t;

    localparam logic [21:0] TRIG_MIN_C  = 22'(TRIG_MIN);
    localparam logic [21:0] ATRASO_M1   = 22'(ATRASO - 1);
    localparam logic [21:0] PAUSA_M1    = 22'(PAUSA - 1);
    localparam logic [21:0] ECO_MAX_C   = 22'(ECO_MAX);
    localparam logic [21:0] CPM_C       = 22'(CICLOS_POR_MM);

    estado_t     estado_q;
    logic [1:0]  sync_q;
    logic        trig_s;
    logic [21:0] cnt_q;
    logic [21:0] largura_q, largura_d;
    logic        echo_q, ocupado_q, erro_q;
    logic [3:0]  d2, d1, d0;
    logic [9:0]  mm_base, mm_total;
    logic        invalido, aceita;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], trigger};
    end
    assign trig_s = sync_q[1];

    assign aceita = (estado_q == S_MEDE_TRIG) && !trig_s && (cnt_q >= TRIG_MIN_C);

`ifdef HCSR04_EMULADOR_RUIDO_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)      lfsr_q <= 16'hACE1;
        else if (aceita) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
`endif

    always_comb begin
        d2       = distancia[11:8];
        d1       = distancia[7:4];
        d0       = distancia[3:0];
        mm_base  = 10'(d2) * 10'd100 + 10'(d1) * 10'd10 + 10'(d0);
`ifdef HCSR04_EMULADOR_RUIDO_EN
        mm_total = mm_base + 10'(lfsr_q[2:0]);
`else
        mm_total = mm_base;
`endif
        // Validity is judged on the programmed distance, so jitter never rescues mm = 0.
        invalido  = sem_objeto || (d2 > 4'd9) || (d1 > 4'd9) || (d0 > 4'd9) || (mm_base == 10'd0);
        largura_d = invalido ? ECO_MAX_C : 22'(mm_total) * CPM_C;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= S_OCIOSO;
            cnt_q     <= '0;
            largura_q <= '0;
            echo_q    <= 1'b0;
            ocupado_q <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            erro_q <= 1'b0;
            case (estado_q)
                S_OCIOSO: if (trig_s) begin
                    cnt_q     <= '0;
                    ocupado_q <= 1'b1;
                    estado_q  <= S_MEDE_TRIG;
                end
                S_MEDE_TRIG: begin
                    if (trig_s) begin
                        if (cnt_q != '1) cnt_q <= cnt_q + 22'd1;
                    end else if (aceita) begin
                        largura_q <= largura_d;
                        cnt_q     <= '0;
                        estado_q  <= S_ATRASO;
                    end else begin
                        erro_q    <= 1'b1;
                        ocupado_q <= 1'b0;
                        estado_q  <= S_OCIOSO;
                    end
                end
                S_ATRASO: begin
                    if (cnt_q == ATRASO_M1) begin
                        cnt_q    <= '0;
                        echo_q   <= 1'b1;
                        estado_q <= S_ECO;
                    end else cnt_q <= cnt_q + 22'd1;
                end
                S_ECO: begin
                    if (cnt_q == largura_q - 22'd1) begin
                        cnt_q    <= '0;
                        echo_q   <= 1'b0;
                        estado_q <= S_PAUSA;
                    end else cnt_q <= cnt_q + 22'd1;
                end
                S_PAUSA: begin
                    if (cnt_q == PAUSA_M1) begin
                        cnt_q     <= '0;
                        ocupado_q <= 1'b0;
                        estado_q  <= S_OCIOSO;
                    end else cnt_q <= cnt_q + 22'd1;
                end
                default: begin
                    cnt_q     <= '0;
                    echo_q    <= 1'b0;
                    ocupado_q <= 1'b0;
                    estado_q  <= S_OCIOSO;
                end
            endcase
        end
    end

    assign echo         = echo_q;
    assign ocupado      = ocupado_q;
    assign erro_trigger = erro_q;
    assign db_estado    = estado_q;
endmodule

// File: tb/tb_hcsr04_emulador.sv
// Directed bench for hcsr04_emulador with shortened timing parameters.
module tb_hcsr04_emulador;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        trigger = 1'b0;
    logic [11:0] distancia = 12'h000;
    logic        sem_objeto = 1'b0;
    logic        echo, ocupado, erro_trigger;
    logic [2:0]  db_estado;
    int tests = 0;
    int fails = 0;

    hcsr04_emulador #(
        .CICLOS_POR_MM(294), .TRIG_MIN(10), .ATRASO(100), .ECO_MAX(2000), .PAUSA(200)
    ) dut (
        .clock(clock), .reset(reset), .trigger(trigger), .distancia(distancia),
        .sem_objeto(sem_objeto), .echo(echo), .ocupado(ocupado),
        .erro_trigger(erro_trigger), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Raw trigger high for n clock edges, starting and ending on a falling edge.
    task automatic pulso(input int n);
        @(negedge clock);
        trigger = 1'b1;
        repeat (n) @(negedge clock);
        trigger = 1'b0;
    endtask

    task automatic medir(input string tag, input logic [11:0] d, input logic sem,
                         input logic [11:0] d_late, input int exp_w);
        int lat, w, p;
        distancia  = d;
        sem_objeto = sem;
        pulso(20);
        lat = 0;
        repeat (5) begin @(negedge clock); lat++; end
        check({tag, "_estado_atraso"}, db_estado, 2);
        distancia  = d_late;
        sem_objeto = 1'b0;
        while (!echo && lat < 1000) begin @(negedge clock); lat++; end
        check({tag, "_latencia"}, lat, 103);
        w = 1;
        while (w < 50000) begin
            @(negedge clock);
            if (!echo) break;
            w++;
        end
        check({tag, "_largura"}, w, exp_w);
        check({tag, "_estado_pausa"}, db_estado, 4);
        check({tag, "_ocupado_pausa"}, ocupado, 1);
        p = 0;
        while (db_estado != 3'd0 && p < 1000) begin @(negedge clock); p++; end
        check({tag, "_pausa"}, p, 200);
        check({tag, "_ocupado_fim"}, ocupado, 0);
    endtask

    initial begin
        int w, n_err, n_echo;
        repeat (3) @(negedge clock);
        check("rst_echo", echo, 0);
        check("rst_ocupado", ocupado, 0);
        check("rst_erro", erro_trigger, 0);
        check("rst_estado", db_estado, 0);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        // Nominal 15.0 cm; the mid-ATRASO change to 5.0 cm must not matter.
        medir("d150", 12'h150, 1'b0, 12'h050, 44100);

        // Short trigger.
        pulso(5);
        n_err = 0; n_echo = 0;
        repeat (20) begin
            @(negedge clock);
            if (erro_trigger) n_err++;
            if (echo) n_echo++;
        end
        check("curto_erro", n_err, 1);
        check("curto_echo", n_echo, 0);
        check("curto_estado", db_estado, 0);

        medir("sem_obj", 12'h150, 1'b1, 12'h150, 2000);
        medir("digito_inv", 12'h1A0, 1'b0, 12'h150, 2000);
        medir("zero", 12'h000, 1'b0, 12'h150, 2000);

        // Triggers during ECO and PAUSA are ignored.
        distancia = 12'h010;
        pulso(20);
        w = 0;
        while (!echo && w < 1000) begin @(negedge clock); w++; end
        check("ign_latencia", w, 103);
        w = 1;
        while (w < 50000) begin
            @(negedge clock);
            if (w == 50) trigger = 1'b1;
            if (w == 70) trigger = 1'b0;
            if (!echo) break;
            w++;
        end
        check("ign_largura", w, 2940);
        check("ign_estado_pausa", db_estado, 4);
        pulso(20);
        w = 0;
        while (db_estado != 3'd0 && w < 1000) begin @(negedge clock); w++; end
        check("ign_volta_ocioso", db_estado, 0);
        n_echo = 0;
        w = 0;
        repeat (150) begin
            @(negedge clock);
            if (echo) n_echo++;
            if (db_estado != 3'd0) w++;
        end
        check("ign_sem_echo", n_echo, 0);
        check("ign_fica_ocioso", w, 0);
        medir("apos_pausa", 12'h012, 1'b0, 12'h012, 3528);

        // Asynchronous reset in the middle of ECO.
        distancia = 12'h010;
        pulso(20);
        w = 0;
        while (!echo && w < 1000) begin @(negedge clock); w++; end
        repeat (20) @(negedge clock);
        check("mid_eco_estado", db_estado, 3);
        #2 reset = 1'b0;
        #1;
        check("rst_async_echo", echo, 0);
        check("rst_async_estado", db_estado, 0);
        check("rst_async_ocupado", ocupado, 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        medir("pos_reset", 12'h005, 1'b0, 12'h005, 1470);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
